// File: rtl/pu_riscv_pfpu_i2f_pipe.sv
// Two-stage integer-to-float converter: S1 takes the magnitude and counts leading zeros,
// S2 normalises, rounds per rm and packs an IEEE-754 result with the inexact flag.
module pu_riscv_pfpu_i2f_pipe #(
  parameter int IW = 64,
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              adv_i,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [2:0]        rm_i,
  input  logic [IW-1:0]     opa_i,
  output logic              rdy_o,
  output logic [EW+MW:0]    result_o,
  output logic              inexact_o
);

  localparam int LW   = $clog2(IW + 1);
  localparam int BIAS = (2 ** (EW - 1)) - 1;

  function automatic logic [LW-1:0] lzc(input logic [IW-1:0] v);
    logic          found;
    logic [LW-1:0] n;
    n     = LW'(IW);
    found = 1'b0;
    for (int i = IW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LW'(IW - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic              sign_s;
  logic [IW-1:0]     mag_s;
  logic              s1_vld_r;
  logic              s1_sign_r;
  logic [IW-1:0]     s1_mag_r;
  logic [LW-1:0]     s1_lz_r;
  logic [2:0]        s1_rm_r;

  logic [IW-1:0]     norm_s;
  logic [IW+MW:0]    ext_s;
  logic [MW-1:0]     mant_s;
  logic              guard_s;
  logic              sticky_s;
  logic              inc_s;
  logic [EW-1:0]     exp_s;
  logic [MW:0]       mant_sum_s;
  logic [EW-1:0]     exp_fin_s;
  logic              zero_s;

  assign sign_s = signed_i & opa_i[IW-1];
  // Two's-complement negate; the most-negative operand maps to 2**(IW-1) exactly.
  assign mag_s  = sign_s ? (~opa_i + {{(IW-1){1'b0}}, 1'b1}) : opa_i;

  // S1 pipeline register: magnitude, leading-zero count, sign, rounding mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_r  <= 1'b0;
      s1_sign_r <= 1'b0;
      s1_mag_r  <= {IW{1'b0}};
      s1_lz_r   <= {LW{1'b0}};
      s1_rm_r   <= 3'b000;
    end else if (flush_i) begin
      s1_vld_r  <= 1'b0;
    end else if (adv_i) begin
      s1_vld_r  <= start_i;
      s1_sign_r <= sign_s;
      s1_mag_r  <= mag_s;
      s1_lz_r   <= lzc(mag_s);
      s1_rm_r   <= rm_i;
    end
  end

  assign norm_s = s1_mag_r << s1_lz_r;
  assign zero_s = ~norm_s[IW-1];
  // Hidden bit dropped and zero padding appended so guard/sticky exist for any IW/MW mix.
  assign ext_s    = {norm_s[IW-2:0], {(MW+2){1'b0}}};
  assign mant_s   = ext_s[IW+MW -: MW];
  assign guard_s  = ext_s[IW];
  assign sticky_s = |ext_s[IW-1:0];

  // Rounding increment decode; reserved encodings fall back to round-to-nearest-even.
  always_comb begin
    inc_s = 1'b0;
    case (s1_rm_r)
      3'b001:  inc_s = 1'b0;
      3'b010:  inc_s = s1_sign_r & (guard_s | sticky_s);
      3'b011:  inc_s = ~s1_sign_r & (guard_s | sticky_s);
      3'b100:  inc_s = guard_s;
      default: inc_s = guard_s & (sticky_s | mant_s[0]);
    endcase
  end

  assign exp_s      = EW'(IW - 1 + BIAS) - EW'(s1_lz_r);
  assign mant_sum_s = {1'b0, mant_s} + {{MW{1'b0}}, inc_s};
  // Carry out of the mantissa leaves a zero fraction and bumps the exponent.
  assign exp_fin_s  = exp_s + {{(EW-1){1'b0}}, mant_sum_s[MW]};

  // S2 output register: packed result, inexact flag and result-valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_o     <= 1'b0;
      result_o  <= {(EW+MW+1){1'b0}};
      inexact_o <= 1'b0;
    end else if (flush_i) begin
      rdy_o     <= 1'b0;
    end else if (adv_i) begin
      rdy_o     <= s1_vld_r;
      result_o  <= zero_s ? {(EW+MW+1){1'b0}} : {s1_sign_r, exp_fin_s, mant_sum_s[MW-1:0]};
      inexact_o <= guard_s | sticky_s;
    end
  end

endmodule

// File: tb/tb_pu_riscv_pfpu_i2f_pipe.sv
// Bench for the i2f pipe: single-precision (IW=64) and double-precision (IW=32) instances,
// directed vectors plus random stimulus against an arithmetic rounding model.
module tb_pu_riscv_pfpu_i2f_pipe;

  typedef struct packed {
    logic        v;
    logic [63:0] res;
    logic        nx;
  } ent_t;

  logic        clk;
  logic        rstn;
  logic        flush_i;
  logic        adv_i;
  logic        start_i;
  logic        signed_i;
  logic [2:0]  rm_i;
  logic [63:0] opa_a;
  logic [31:0] opa_b;
  logic        rdy_a;
  logic [31:0] res_a;
  logic        nx_a;
  logic        rdy_b;
  logic [63:0] res_b;
  logic        nx_b;

  int n_chk;
  int n_err;

  ent_t q1[$];
  ent_t q2[$];

  logic        kuse;
  logic [63:0] kres;
  logic        knx;
  logic        kuse2;
  logic [63:0] kres2;
  logic        knx2;

  pu_riscv_pfpu_i2f_pipe #(.IW(64), .EW(8), .MW(23)) dut_s (
    .clk(clk), .rstn(rstn), .flush_i(flush_i), .adv_i(adv_i), .start_i(start_i),
    .signed_i(signed_i), .rm_i(rm_i), .opa_i(opa_a),
    .rdy_o(rdy_a), .result_o(res_a), .inexact_o(nx_a)
  );

  pu_riscv_pfpu_i2f_pipe #(.IW(32), .EW(11), .MW(52)) dut_d (
    .clk(clk), .rstn(rstn), .flush_i(flush_i), .adv_i(adv_i), .start_i(start_i),
    .signed_i(signed_i), .rm_i(rm_i), .opa_i(opa_b),
    .rdy_o(rdy_b), .result_o(res_b), .inexact_o(nx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact value m scaled into [2**mw, 2**(mw+1)) by integer division; remainder drives rounding.
  function automatic ent_t model(input int iw, input int ew, input int mw, input logic sg,
                                 input logic [2:0] rm, input logic [63:0] op);
    ent_t          r;
    logic [127:0]  m, q, rem, half;
    logic          neg, inc, nx;
    int            e, sh;
    m   = {64'd0, op} & ((128'd1 << iw) - 128'd1);
    neg = sg && m[iw-1];
    if (neg) m = (128'd1 << iw) - m;
    r.v = 1'b1;
    if (m == 128'd0) begin
      r.res = 64'd0;
      r.nx  = 1'b0;
      return r;
    end
    e = 0;
    for (int i = 0; i < iw; i++) if (m[i]) e = i;
    if (e <= mw) begin
      q   = m << (mw - e);
      nx  = 1'b0;
      inc = 1'b0;
    end else begin
      sh   = e - mw;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 128'd1 << (sh - 1);
      nx   = (rem != 128'd0);
      case (rm)
        3'd1:    inc = 1'b0;
        3'd2:    inc = neg && nx;
        3'd3:    inc = !neg && nx;
        3'd4:    inc = (rem >= half);
        default: inc = (rem > half) || ((rem == half) && q[0]);
      endcase
    end
    q = q + {127'd0, inc};
    if (q[mw+1]) begin
      q = q >> 1;
      e = e + 1;
    end
    m = ({127'd0, neg} << (ew + mw)) | (128'(e + (1 << (ew - 1)) - 1) << mw)
        | (q & ((128'd1 << mw) - 128'd1));
    r.res = m[63:0];
    r.nx  = nx;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t inv;
    inv = '{v: 1'b0, res: 64'd0, nx: 1'b0};
    q1.delete();
    q2.delete();
    q1.push_back(inv);
    q1.push_back(inv);
    q2.push_back(inv);
    q2.push_back(inv);
  endtask

  task automatic check_outputs();
    chk("rdy_s", {63'd0, rdy_a}, {63'd0, q1[0].v});
    if (q1[0].v) begin
      chk("res_s", {32'd0, res_a}, q1[0].res);
      chk("nx_s", {63'd0, nx_a}, {63'd0, q1[0].nx});
    end
    chk("rdy_d", {63'd0, rdy_b}, {63'd0, q2[0].v});
    if (q2[0].v) begin
      chk("res_d", res_b, q2[0].res);
      chk("nx_d", {63'd0, nx_b}, {63'd0, q2[0].nx});
    end
  endtask

  // One clock: drive, advance the transaction queues, then sample 1 time unit after the edge.
  task automatic step(input logic adv, input logic fl, input logic st, input logic sg,
                      input logic [2:0] rm, input logic [63:0] op, input logic [31:0] op2);
    ent_t e1, e2;
    adv_i = adv; flush_i = fl; start_i = st; signed_i = sg; rm_i = rm;
    opa_a = op; opa_b = op2;
    e1 = model(64, 8, 23, sg, rm, op);
    if (kuse) begin e1.res = kres; e1.nx = knx; end
    e1.v = st;
    e2 = model(32, 11, 52, sg, rm, {32'd0, op2});
    if (kuse2) begin e2.res = kres2; e2.nx = knx2; end
    e2.v = st;
    @(posedge clk);
    if (fl) begin
      foreach (q1[i]) q1[i].v = 1'b0;
      foreach (q2[i]) q2[i].v = 1'b0;
    end else if (adv) begin
      q1.push_back(e1); void'(q1.pop_front());
      q2.push_back(e2); void'(q2.pop_front());
    end
    kuse = 1'b0;
    kuse2 = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic issue_k(input logic sg, input logic [2:0] rm, input logic [63:0] op,
                         input logic [31:0] res, input logic nx);
    kuse = 1'b1; kres = {32'd0, res}; knx = nx;
    step(1'b1, 1'b0, 1'b1, sg, rm, op, $urandom);
  endtask

  task automatic issue_k2(input logic sg, input logic [2:0] rm, input logic [31:0] op2,
                          input logic [63:0] res, input logic nx);
    kuse2 = 1'b1; kres2 = res; knx2 = nx;
    step(1'b1, 1'b0, 1'b1, sg, rm, {$urandom, $urandom}, op2);
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] r2;
    n_chk = 0; n_err = 0;
    kuse = 1'b0; kuse2 = 1'b0; kres = 64'd0; kres2 = 64'd0; knx = 1'b0; knx2 = 1'b0;
    rstn = 1'b0; flush_i = 1'b0; adv_i = 1'b0; start_i = 1'b0; signed_i = 1'b0;
    rm_i = 3'd0; opa_a = 64'd0; opa_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_rdy_s", {63'd0, rdy_a}, 64'd0);
    chk("rst_res_s", {32'd0, res_a}, 64'd0);
    chk("rst_nx_s", {63'd0, nx_a}, 64'd0);
    chk("rst_rdy_d", {63'd0, rdy_b}, 64'd0);
    chk("rst_res_d", res_b, 64'd0);
    chk("rst_nx_d", {63'd0, nx_b}, 64'd0);
    model_reset();
    rstn = 1'b1;

    // Back-to-back directed vectors with a 3-cycle stall after the fourth.
    issue_k(1'b1, 3'd0, 64'd1, 32'h3F80_0000, 1'b0);
    issue_k(1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hBF80_0000, 1'b0);
    issue_k(1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h5F80_0000, 1'b1);
    issue_k(1'b1, 3'd2, 64'd0, 32'h0000_0000, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 64'd5, 32'd5);
    issue_k(1'b0, 3'd0, 64'h0000_0000_0100_0001, 32'h4B80_0000, 1'b1);
    issue_k(1'b0, 3'd3, 64'h0000_0000_0100_0001, 32'h4B80_0001, 1'b1);
    issue_k(1'b0, 3'd0, 64'h0000_0000_0100_0003, 32'h4B80_0002, 1'b1);
    issue_k(1'b0, 3'd4, 64'h0000_0000_0100_0003, 32'h4B80_0002, 1'b1);
    issue_k(1'b1, 3'd2, 64'hFFFF_FFFF_FEFF_FFFF, 32'hCB80_0001, 1'b1);
    issue_k(1'b1, 3'd1, 64'hFFFF_FFFF_FEFF_FFFF, 32'hCB80_0000, 1'b1);
    issue_k(1'b1, 3'd0, 64'h8000_0000_0000_0000, 32'hDF00_0000, 1'b0);
    issue_k(1'b0, 3'd0, 64'hFFFF_FF00_0000_0000, 32'h5F7F_FFFF, 1'b0);
    issue_k2(1'b1, 3'd0, 32'hFFFF_FFF9, 64'hC01C_0000_0000_0000, 1'b0);
    issue_k2(1'b0, 3'd0, 32'hFFFF_FFFF, 64'h41EF_FFFF_FFE0_0000, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 32'd0);

    // Flush with two operations in flight.
    step(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 64'd123, 32'd77);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 64'h0000_1234_5678_9ABC, 32'h8000_0001);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 32'd0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 32'd0);

    // Asynchronous reset pulse mid-stream.
    step(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FF00, 32'hFFFF_FF00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'd999, 32'd999);
    rstn = 1'b0;
    #1;
    chk("arst_rdy_s", {63'd0, rdy_a}, 64'd0);
    chk("arst_rdy_d", {63'd0, rdy_b}, 64'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'd3, 32'd3);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 32'd0);

    // Random traffic with stalls, flushes and every rounding-mode encoding.
    for (int i = 0; i < 400; i++) begin
      r  = {$urandom, $urandom} >> $urandom_range(0, 63);
      r2 = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) begin
        r  = ~r;
        r2 = ~r2;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), r, r2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
